// File: rtl/keyboard_pkg.sv
// Shared constants and types for the PS/2 keyboard controller.
// Register offsets, STATUS/CTRL bit positions and receiver states.
package keyboard_pkg;

  localparam logic [1:0] KBD_STATUS = 2'd0;
  localparam logic [1:0] KBD_DATA   = 2'd1;
  localparam logic [1:0] KBD_CTRL   = 2'd2;

  localparam int ST_NEMPTY = 0;
  localparam int ST_OVF    = 1;
  localparam int ST_PERR   = 2;
  localparam int ST_FERR   = 3;
  localparam int ST_CNT_LO = 8;

  localparam int CTRL_POP = 0;
  localparam int CTRL_CLR = 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  // True when data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_ok(
    input logic [7:0] d,
    input logic       p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_receiver.sv
// PS/2 frame receiver: line sync, falling-edge detect, frame FSM and
// idle timeout. Emits one-cycle byte/error pulses at the stop bit.
module ps2_receiver
  import keyboard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       perr_pulse,
  output logic       ferr_pulse
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_s1, clk_s2, clk_h;
  logic dat_s1, dat_s2;
  logic fall;

  ps2_state_t state, state_d;
  logic [2:0] bit_cnt, bit_d;
  logic [7:0] shreg, sh_d;
  logic       par, par_d;
  logic [TW-1:0] tcnt;
  logic       timeout;

  // Two-flop synchronizers plus a history flop on the clock line.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_h  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      clk_h  <= clk_s2;
      dat_s1 <= ps2_data_in;
      dat_s2 <= dat_s1;
    end
  end

  assign fall    = ~clk_s2 & clk_h;
  assign timeout = (state != IDLE) &&
                   (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // Idle counter: restarts on every PS/2 edge, runs only mid-frame.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      tcnt <= '0;
    else if (fall || state == IDLE || timeout)
      tcnt <= '0;
    else
      tcnt <= tcnt + 1'b1;
  end

  // Frame state and datapath registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_d;
      shreg   <= sh_d;
      par     <= par_d;
    end
  end

  // Next-state and stop-bit verdict; an edge always beats the timeout.
  always_comb begin
    state_d    = state;
    bit_d      = bit_cnt;
    sh_d       = shreg;
    par_d      = par;
    byte_valid = 1'b0;
    perr_pulse = 1'b0;
    ferr_pulse = 1'b0;
    if (fall) begin
      unique case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
        DATA: begin
          sh_d  = {dat_s2, shreg[7:1]};
          bit_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s2;
          state_d = STOP;
        end
        STOP: begin
          state_d    = IDLE;
          perr_pulse = ~odd_ok(shreg, par);
          ferr_pulse = ~dat_s2;
          byte_valid = odd_ok(shreg, par) & dat_s2;
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d = IDLE;
    end
  end

  assign byte_data = shreg;

endmodule

// File: rtl/keyboard_controller.sv
// PS/2 keyboard port: receiver, scancode FIFO and polled registers.
// STATUS/DATA reads return pre-edge state with one cycle of latency.
module keyboard_controller
  import keyboard_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic [3:0]  write_enable_in,
  output logic [31:0] data_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       perr_pulse;
  logic       ferr_pulse;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          ovf, perr, ferr;

  logic [1:0]  sel;
  logic        wr, pop_req, clr, pop, push, full, ovf_set;
  logic [31:0] rd_data;
  logic        unused_bits;

  ps2_receiver #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .perr_pulse (perr_pulse),
    .ferr_pulse (ferr_pulse)
  );

  assign sel     = addr_in[3:2];
  assign wr      = |write_enable_in;
  assign pop_req = wr && sel == KBD_CTRL && data_in[CTRL_POP];
  assign clr     = wr && sel == KBD_CTRL && data_in[CTRL_CLR];
  assign full    = count == CW'(FIFO_DEPTH);
  assign pop     = pop_req && count != '0;
  assign push    = byte_valid && (!full || pop);
  assign ovf_set = byte_valid && full && !pop;

  assign unused_bits = ^{addr_in[31:4], addr_in[1:0], data_in[31:2]};

  // Scancode storage; no reset so it maps onto distributed RAM.
  always_ff @(posedge clk_in) begin
    if (push)
      mem[wr_ptr] <= byte_data;
  end

  // Pointers and occupancy; simultaneous push and pop leave count alone.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ovf  <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ovf  <= ovf_set    | (ovf  & ~clr);
      perr <= perr_pulse | (perr & ~clr);
      ferr <= ferr_pulse | (ferr & ~clr);
    end
  end

  // Read mux over current (pre-edge) register state.
  always_comb begin
    rd_data = '0;
    case (sel)
      KBD_STATUS: begin
        rd_data[ST_NEMPTY]            = count != '0;
        rd_data[ST_OVF]               = ovf;
        rd_data[ST_PERR]              = perr;
        rd_data[ST_FERR]              = ferr;
        rd_data[ST_CNT_LO+7:ST_CNT_LO] = 8'(count);
      end
      KBD_DATA: begin
        if (count != '0)
          rd_data[7:0] = mem[rd_ptr];
      end
      default: rd_data = '0;
    endcase
  end

  // Registered read port.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      data_out <= '0;
    else
      data_out <= rd_data;
  end

endmodule

// File: tb/tb_keyboard_controller.sv
// Self-checking bench for keyboard_controller: directed vector table,
// multi-cycle corner sequences and random frames against a queue model.
module tb_keyboard_controller;

  localparam int TMO   = 200;
  localparam int DEPTH = 16;
  localparam int H     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  we = '0;
  logic [31:0] rdata;

  int tests = 0;
  int fails = 0;

  logic [7:0] q[$];
  bit m_ovf, m_perr, m_ferr;

  typedef struct {
    bit          send;
    logic [7:0]  b;
    bit          bad_par;
    bit          stop;
    logic [31:0] ctrl;
    logic [31:0] exp_status;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  keyboard_controller #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .ps2_clk_in     (ps2_clk),
    .ps2_data_in    (ps2_dat),
    .addr_in        (addr),
    .data_in        (wdata),
    .write_enable_in(we),
    .data_out       (rdata)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] off, output logic [31:0] v);
    addr = {28'b0, off, 2'b00};
    tick(1);
    v = rdata;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] v);
    addr  = {28'b0, off, 2'b00};
    wdata = v;
    we    = 4'hF;
    tick(1);
    we    = 4'h0;
    wdata = '0;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    tick(H);
    ps2_clk = 1'b0;
    tick(H);
    ps2_clk = 1'b1;
  endtask

  // Full frame; optionally presents a CTRL pop in the stop-bit commit cycle.
  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit stop, input bit pop_at_commit);
    logic p;
    p = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_dat = stop;
    tick(H);
    ps2_clk = 1'b0;
    if (pop_at_commit) begin
      tick(2);
      addr  = 32'h8;
      wdata = 32'h1;
      we    = 4'hF;
      tick(1);
      we    = 4'h0;
      wdata = '0;
      tick(H - 3);
    end else begin
      tick(H);
    end
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    tick(4);
  endtask

  function automatic void model_frame(input logic [7:0] b,
                                      input bit bad_par, input bit stop);
    if (bad_par) m_perr = 1'b1;
    if (!stop) m_ferr = 1'b1;
    if (!bad_par && stop) begin
      if (q.size() < DEPTH) q.push_back(b);
      else m_ovf = 1'b1;
    end
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[0] = q.size() != 0;
    s[1] = m_ovf;
    s[2] = m_perr;
    s[3] = m_ferr;
    s[15:8] = 8'(q.size());
    return s;
  endfunction

  function automatic logic [31:0] m_data();
    return (q.size() != 0) ? {24'b0, q[0]} : 32'b0;
  endfunction

  task automatic ctrl(input logic [31:0] v);
    wr(2'd2, v);
    if (v[0] && q.size() != 0) void'(q.pop_front());
    if (v[1]) begin
      m_ovf  = 1'b0;
      m_perr = 1'b0;
      m_ferr = 1'b0;
    end
  endtask

  task automatic check_regs(input string name);
    logic [31:0] v;
    rd(2'd0, v);
    check({name, "_status"}, v, m_status());
    rd(2'd1, v);
    check({name, "_data"}, v, m_data());
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  rb;
    int          kind;

    vecs[0] = '{1, 8'h1C, 0, 1, 32'h0, 32'h0000_0101, 32'h0000_001C};
    vecs[1] = '{0, 8'h00, 0, 1, 32'h1, 32'h0, 32'h0};
    vecs[2] = '{1, 8'h1C, 1, 1, 32'h0, 32'h0000_0004, 32'h0};
    vecs[3] = '{0, 8'h00, 0, 1, 32'h2, 32'h0, 32'h0};
    vecs[4] = '{1, 8'h33, 0, 0, 32'h0, 32'h0000_0008, 32'h0};
    vecs[5] = '{0, 8'h00, 0, 1, 32'h2, 32'h0, 32'h0};
    vecs[6] = '{0, 8'h00, 0, 1, 32'h1, 32'h0, 32'h0};
    vecs[7] = '{1, 8'hA5, 0, 1, 32'h0, 32'h0000_0101, 32'h0000_00A5};
    vecs[8] = '{0, 8'h00, 0, 1, 32'h3, 32'h0, 32'h0};

    tick(2);
    check("reset_data_out", rdata, 32'h0);
    rst = 1'b0;
    tick(1);
    rd(2'd0, v);
    check("reset_status", v, 32'h0);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].send)
        send_frame(vecs[i].b, vecs[i].bad_par, vecs[i].stop, 0);
      if (vecs[i].ctrl != 0)
        wr(2'd2, vecs[i].ctrl);
      rd(2'd0, v);
      check($sformatf("vec%0d_status", i), v, vecs[i].exp_status);
      rd(2'd1, v);
      check($sformatf("vec%0d_data", i), v, vecs[i].exp_data);
    end

    send_frame(8'h42, 0, 1, 0);
    model_frame(8'h42, 0, 1);
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd3, 32'h3);
    check_regs("ignored_writes");
    rd(2'd2, v);
    check("ctrl_reads_0", v, 32'h0);
    rd(2'd3, v);
    check("off_c_reads_0", v, 32'h0);
    ctrl(32'h1);

    for (int i = 1; i <= 17; i++) begin
      send_frame(8'(i), 0, 1, 0);
      model_frame(8'(i), 0, 1);
    end
    rd(2'd0, v);
    check("ovf_status", v, 32'h0000_1003);
    rd(2'd1, v);
    check("ovf_head", v, 32'h1);
    for (int i = 0; i < 16; i++) begin
      rd(2'd1, v);
      check($sformatf("ovf_pop%0d", i), v, 32'(i + 1));
      ctrl(32'h1);
    end
    rd(2'd0, v);
    check("ovf_drained", v, 32'h0000_0002);
    ctrl(32'h1);
    rd(2'd0, v);
    check("pop_at_empty", v, 32'h0000_0002);
    ctrl(32'h2);
    check_regs("ovf_cleared");

    for (int i = 0; i < 16; i++) begin
      send_frame(8'h20 + 8'(i), 0, 1, 0);
      model_frame(8'h20 + 8'(i), 0, 1);
    end
    send_frame(8'h5A, 0, 1, 1);
    void'(q.pop_front());
    q.push_back(8'h5A);
    rd(2'd0, v);
    check("collide_status", v, 32'h0000_1001);
    for (int i = 0; i < 16; i++) begin
      rd(2'd1, v);
      check($sformatf("collide_pop%0d", i), v, m_data());
      ctrl(32'h1);
    end
    check_regs("collide_empty");

    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    tick(TMO + 1 - 2 * H);
    send_frame(8'h29, 0, 1, 0);
    model_frame(8'h29, 0, 1);
    check_regs("timeout_abort");
    ctrl(32'h1);

    rb = 8'h29;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(rb[i]);
    tick(TMO - 2 * H);
    for (int i = 4; i < 8; i++) ps2_bit(rb[i]);
    ps2_bit(~(^rb));
    ps2_bit(1'b1);
    tick(4);
    model_frame(rb, 0, 1);
    check_regs("timeout_edge_kept");
    ctrl(32'h1);

    for (int i = 0; i < 3; i++) begin
      send_frame(8'h61 + 8'(i), 0, 1, 0);
      model_frame(8'h61 + 8'(i), 0, 1);
    end
    rd(2'd0, v);
    check("pre_reset_status", v, 32'h0000_0301);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_dat = 1'b0;
    tick(H);
    ps2_clk = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("reset_async_data_out", rdata, 32'h0);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    @(posedge clk);
    #1;
    tick(1);
    rst = 1'b0;
    q.delete();
    m_ovf  = 1'b0;
    m_perr = 1'b0;
    m_ferr = 1'b0;
    rd(2'd0, v);
    check("post_reset_status", v, 32'h0);
    send_frame(8'h77, 0, 1, 0);
    model_frame(8'h77, 0, 1);
    check_regs("post_reset_frame");

    for (int i = 0; i < 40; i++) begin
      rb   = 8'($urandom);
      kind = $urandom_range(0, 9);
      send_frame(rb, kind == 0, kind != 1, 0);
      model_frame(rb, kind == 0, kind != 1);
      check_regs($sformatf("rand%0d", i));
      if ($urandom_range(0, 2) == 0)
        ctrl(32'($urandom_range(0, 3)));
    end
    check_regs("rand_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
